// File: rtl/si_alu_arbiter_if.sv
// si_alu_arbiter_if: request, response and ALU-side signal bundle for si_alu_arbiter
// Suffixes are from the arbiter's point of view (_i into it, _o out of it).
// slave modport: the arbiter. master modport: requesters plus the ALU itself.
interface si_alu_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int INST_AW  = 32,
  parameter int REG_DW   = 32,
  parameter int ALUOP_DW = 5
);
  logic [NUM_REQ-1:0]          req_valid_i, req_ready_o, req_br_en_i, req_jmp_en_i;
  logic [NUM_REQ*ALUOP_DW-1:0] req_opcode_i;
  logic [NUM_REQ*REG_DW-1:0]   req_op1_i, req_op2_i;
  logic [NUM_REQ*INST_AW-1:0]  req_pc_i, req_br_pc_i, req_jmp_pc_i;
  logic [ALUOP_DW-1:0]         alu_opcode_o;
  logic [REG_DW-1:0]           alu_op1_o, alu_op2_o, alu_result_i;
  logic [INST_AW-1:0]          alu_pc_o, alu_br_pc_o, alu_jmp_pc_o, alu_ctrl_pc_i;
  logic                        alu_br_en_o, alu_jmp_en_o, alu_ctrl_en_i;
  logic [NUM_REQ-1:0]          rsp_valid_o, rsp_ready_i, rsp_ctrl_en_o;
  logic [NUM_REQ*REG_DW-1:0]   rsp_result_o;
  logic [NUM_REQ*INST_AW-1:0]  rsp_ctrl_pc_o;
  modport slave (
    input  req_valid_i, req_opcode_i, req_op1_i, req_op2_i, req_pc_i,
           req_br_en_i, req_br_pc_i, req_jmp_en_i, req_jmp_pc_i,
           alu_result_i, alu_ctrl_en_i, alu_ctrl_pc_i, rsp_ready_i,
    output req_ready_o, alu_opcode_o, alu_op1_o, alu_op2_o, alu_pc_o,
           alu_br_en_o, alu_br_pc_o, alu_jmp_en_o, alu_jmp_pc_o,
           rsp_valid_o, rsp_result_o, rsp_ctrl_en_o, rsp_ctrl_pc_o
  );
  modport master (
    output req_valid_i, req_opcode_i, req_op1_i, req_op2_i, req_pc_i,
           req_br_en_i, req_br_pc_i, req_jmp_en_i, req_jmp_pc_i,
           alu_result_i, alu_ctrl_en_i, alu_ctrl_pc_i, rsp_ready_i,
    input  req_ready_o, alu_opcode_o, alu_op1_o, alu_op2_o, alu_pc_o,
           alu_br_en_o, alu_br_pc_o, alu_jmp_en_o, alu_jmp_pc_o,
           rsp_valid_o, rsp_result_o, rsp_ctrl_en_o, rsp_ctrl_pc_o
  );
endinterface

// File: rtl/si_alu_arbiter.sv
// si_alu_arbiter: round-robin sharing of one combinational ALU between NUM_REQ requesters
// Ports: clk; rst (async, active low); bus (slave modport of si_alu_arbiter_if)
// carrying the request channels, the ALU drive/return and the one-entry response slots.
module si_alu_arbiter #(
  parameter int                 NUM_REQ    = 2,
  parameter int                 INST_AW    = 32,
  parameter int                 REG_DW     = 32,
  parameter int                 ALUOP_DW   = 5,
  parameter int                 MUL_CYCLES = 2,
  parameter logic [ALUOP_DW-1:0] OP_MUL    = ALUOP_DW'(2)
) (
  input logic             clk,
  input logic             rst,
  si_alu_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MUL_CYCLES + 1);
  typedef enum logic {IDLE, MUL_WAIT} state_e;
  typedef struct packed {
    logic [ALUOP_DW-1:0] op;
    logic [REG_DW-1:0]   op1;
    logic [REG_DW-1:0]   op2;
    logic [INST_AW-1:0]  pc;
    logic                br_en;
    logic [INST_AW-1:0]  br_pc;
    logic                jmp_en;
    logic [INST_AW-1:0]  jmp_pc;
  } alu_req_t;
  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              last_q, own_q, gnt_idx, cap_idx, j;
  alu_req_t                   hold_q, gnt_req, drv;
  logic [NUM_REQ-1:0]         elig, rsp_v_q, ready;
  logic [NUM_REQ-1:0]         cen_q;
  logic [NUM_REQ*REG_DW-1:0]  res_q;
  logic [NUM_REQ*INST_AW-1:0] cpc_q;
  logic                       gnt_any, is_mul, cap;
  // A full slot is eligible again only if it is being popped this cycle.
  assign elig = bus.req_valid_i & (~rsp_v_q | bus.rsp_ready_i);
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_q;
    j       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = IW'((int'(last_q) + i) % NUM_REQ);
      if (!gnt_any && state_q == IDLE && elig[j]) begin
        gnt_any = 1'b1;
        gnt_idx = j;
      end
    end
  end
  always_comb begin
    gnt_req = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt_idx == IW'(k))
        gnt_req = '{op:     bus.req_opcode_i[k*ALUOP_DW +: ALUOP_DW],
                    op1:    bus.req_op1_i[k*REG_DW +: REG_DW],
                    op2:    bus.req_op2_i[k*REG_DW +: REG_DW],
                    pc:     bus.req_pc_i[k*INST_AW +: INST_AW],
                    br_en:  bus.req_br_en_i[k],
                    br_pc:  bus.req_br_pc_i[k*INST_AW +: INST_AW],
                    jmp_en: bus.req_jmp_en_i[k],
                    jmp_pc: bus.req_jmp_pc_i[k*INST_AW +: INST_AW]};
  end
  assign is_mul = MUL_CYCLES > 1 && gnt_req.op == OP_MUL;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (gnt_any && is_mul ? MUL_WAIT : IDLE)
                              : (cnt_q == CW'(1) ? IDLE : MUL_WAIT);
    cnt_d   = state_q == MUL_WAIT ? cnt_q - CW'(1)
                                  : (gnt_any && is_mul ? CW'(MUL_CYCLES - 1) : cnt_q);
  end
  // The MUL result is taken on the last held cycle; plain ops are taken at the grant edge.
  always_comb begin
    ready   = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
    drv     = state_q == MUL_WAIT ? hold_q : (gnt_any ? gnt_req : '0);
    cap     = state_q == MUL_WAIT ? cnt_q == CW'(1) : gnt_any && !is_mul;
    cap_idx = state_q == MUL_WAIT ? own_q : gnt_idx;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      last_q <= IW'(NUM_REQ - 1);
      own_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (gnt_any) begin
        last_q <= gnt_idx;
        own_q  <= gnt_idx;
        hold_q <= gnt_req;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rsp_v_q <= '0;
      cen_q   <= '0;
      res_q   <= '0;
      cpc_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (cap && cap_idx == IW'(k)) begin
          rsp_v_q[k]                   <= 1'b1;
          cen_q[k]                     <= bus.alu_ctrl_en_i;
          res_q[k*REG_DW +: REG_DW]    <= bus.alu_result_i;
          cpc_q[k*INST_AW +: INST_AW]  <= bus.alu_ctrl_pc_i;
        end else if (bus.rsp_ready_i[k]) begin
          rsp_v_q[k] <= 1'b0;
        end
    end
  assign bus.req_ready_o   = ready;
  assign bus.alu_opcode_o  = drv.op;
  assign bus.alu_op1_o     = drv.op1;
  assign bus.alu_op2_o     = drv.op2;
  assign bus.alu_pc_o      = drv.pc;
  assign bus.alu_br_en_o   = drv.br_en;
  assign bus.alu_br_pc_o   = drv.br_pc;
  assign bus.alu_jmp_en_o  = drv.jmp_en;
  assign bus.alu_jmp_pc_o  = drv.jmp_pc;
  assign bus.rsp_valid_o   = rsp_v_q;
  assign bus.rsp_result_o  = res_q;
  assign bus.rsp_ctrl_en_o = cen_q;
  assign bus.rsp_ctrl_pc_o = cpc_q;
endmodule

// File: tb/tb_si_alu_arbiter.sv
// tb_si_alu_arbiter: directed checks of si_alu_arbiter with a small behavioural ALU
module tb_si_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [1:0] g;
  always #5 clk = ~clk;
  si_alu_arbiter_if #(.NUM_REQ(2)) b ();
  si_alu_arbiter #(.NUM_REQ(2), .MUL_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(b));
  // ALU: 1=ADD, 2=MUL, 3=BNE (control taken when operands differ), jump always taken.
  always_comb begin
    b.alu_result_i  = b.alu_opcode_o == 5'd1 ? b.alu_op1_o + b.alu_op2_o
                    : b.alu_opcode_o == 5'd2 ? b.alu_op1_o * b.alu_op2_o : 32'd0;
    b.alu_ctrl_en_i = b.alu_jmp_en_o || (b.alu_opcode_o == 5'd3 && b.alu_br_en_o && b.alu_op1_o != b.alu_op2_o);
    b.alu_ctrl_pc_i = b.alu_jmp_en_o ? b.alu_jmp_pc_o : b.alu_br_pc_o;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int k, input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] c, input logic br, input logic [31:0] bpc);
    b.req_valid_i[k]          = v;
    b.req_opcode_i[k*5 +: 5]  = op;
    b.req_op1_i[k*32 +: 32]   = a;
    b.req_op2_i[k*32 +: 32]   = c;
    b.req_br_en_i[k]          = br;
    b.req_br_pc_i[k*32 +: 32] = bpc;
  endtask
  initial begin
    b.req_valid_i = '0; b.req_opcode_i = '0; b.req_op1_i = '0; b.req_op2_i = '0;
    b.req_pc_i = '0; b.req_br_en_i = '0; b.req_br_pc_i = '0; b.req_jmp_en_i = '0;
    b.req_jmp_pc_i = '0; b.rsp_ready_i = '0;
    tick(); tick();
    chk("rst_ready", b.req_ready_o, 2'b00);
    chk("rst_rsp_valid", b.rsp_valid_o, 2'b00);
    chk("rst_result", b.rsp_result_o, 64'd0);
    chk("rst_alu_op", b.alu_opcode_o, 5'd0);
    rst = 1'b1;
    b.rsp_ready_i = 2'b11;
    set_req(0, 1, 1, 3, 4, 0, 0);
    #1;
    chk("t1_ready", b.req_ready_o, 2'b01);
    chk("t1_alu_op1", b.alu_op1_o, 32'd3);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_rsp_valid", b.rsp_valid_o, 2'b01);
    chk("t1_result", b.rsp_result_o[31:0], 32'd7);
    chk("t1_ctrl_en", b.rsp_ctrl_en_o, 2'b00);
    chk("t1_idle_ready", b.req_ready_o, 2'b00);
    tick();
    chk("t1_pop", b.rsp_valid_o, 2'b00);
    set_req(0, 1, 1, 10, 1, 0, 0);
    set_req(1, 1, 1, 20, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      chk("t2_grant", b.req_ready_o, g);
      tick();
      chk("t2_rsp", b.rsp_valid_o, g);
      chk("t2_res", g == 2'b10 ? b.rsp_result_o[63:32] : b.rsp_result_o[31:0], g == 2'b10 ? 32'd22 : 32'd11);
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0, 0);
    tick();
    set_req(1, 1, 3, 1, 2, 1, 32'h8000_0040);
    #1;
    chk("t3_ready", b.req_ready_o, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_valid", b.rsp_valid_o, 2'b10);
    chk("t3_ctrl_en", b.rsp_ctrl_en_o, 2'b10);
    chk("t3_ctrl_pc", b.rsp_ctrl_pc_o[63:32], 32'h8000_0040);
    tick();
    set_req(0, 1, 2, 6, 7, 0, 0);
    set_req(1, 1, 1, 5, 5, 0, 0);
    #1;
    chk("t4_grant", b.req_ready_o, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_hold_ready", b.req_ready_o, 2'b00);
      chk("t4_hold_valid", b.rsp_valid_o, 2'b00);
      chk("t4_hold_op", b.alu_opcode_o, 5'd2);
      tick();
    end
    #1;
    chk("t4_mul_valid", b.rsp_valid_o, 2'b01);
    chk("t4_mul_res", b.rsp_result_o[31:0], 32'd42);
    chk("t4_r1_grant", b.req_ready_o, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_r1_valid", b.rsp_valid_o, 2'b10);
    chk("t4_r1_res", b.rsp_result_o[63:32], 32'd10);
    tick();
    b.rsp_ready_i = 2'b10;
    set_req(0, 1, 1, 1, 1, 0, 0);
    set_req(1, 1, 1, 7, 0, 0, 0);
    #1;
    chk("t5_r0_grant", b.req_ready_o, 2'b01);
    tick();
    chk("t5_r1_a", b.req_ready_o, 2'b10);
    tick();
    chk("t5_both_full", b.rsp_valid_o, 2'b11);
    chk("t5_r0_held", b.rsp_result_o[31:0], 32'd2);
    chk("t5_r1_b", b.req_ready_o, 2'b10);
    tick();
    b.rsp_ready_i = 2'b11;
    set_req(0, 1, 1, 100, 1, 0, 0);
    #1;
    chk("t5_regrant", b.req_ready_o, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_refill_valid", b.rsp_valid_o, 2'b01);
    chk("t5_refill_res", b.rsp_result_o[31:0], 32'd101);
    tick();
    b.rsp_ready_i = 2'b00;
    set_req(0, 1, 1, 2, 2, 0, 0);
    #1;
    chk("t6_r0_grant", b.req_ready_o, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 1, 2, 3, 3, 0, 0);
    #1;
    chk("t6_mul_grant", b.req_ready_o, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_pre_rst", b.rsp_valid_o, 2'b01);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", b.rsp_valid_o, 2'b00);
    chk("t6_rst_ready", b.req_ready_o, 2'b00);
    chk("t6_rst_result", b.rsp_result_o, 64'd0);
    tick(); tick();
    rst = 1'b1;
    b.rsp_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_mul", b.rsp_valid_o, 2'b00);
    end
    set_req(0, 1, 1, 1, 1, 0, 0);
    set_req(1, 1, 1, 1, 1, 0, 0);
    #1;
    chk("t6_first_r0", b.req_ready_o, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0, 0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
